// File: rtl/calc_pkg.sv
// Shared types and defaults for the sequential calculator ALU.
package calc_pkg;

    localparam int OPW_DEF  = 5;
    localparam int RESW_DEF = 12;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/calc_alu_seq_if.sv
// Request/result bundle between a requester (master) and calc_alu_seq (slave).
interface calc_alu_seq_if
    import calc_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int RESW = RESW_DEF
) ();

    logic            start;
    logic [OPW-1:0]  A;
    logic [OPW-1:0]  B;
    logic [1:0]      Select;
    logic [RESW-1:0] res;
    logic [1:0]      Select_out;
    logic            neg;
    logic            err;
    logic            busy;
    logic            done;

    modport master (
        output start, A, B, Select,
        input  res, Select_out, neg, err, busy, done
    );

    modport slave (
        input  start, A, B, Select,
        output res, Select_out, neg, err, busy, done
    );

endinterface

// File: rtl/calc_iter_step.sv
// One iteration of shift-add multiply or restoring divide.
// Multiply: {acc, shf} is the partial product, shf starts as the multiplier.
// Divide:   acc is the partial remainder, shf shifts the dividend out and
//           the quotient bits in.
module calc_iter_step
    import calc_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic [OPW:0]   acc_i,
    input  logic [OPW-1:0] shf_i,
    input  logic [OPW-1:0] opd_i,
    input  op_t            op_i,
    output logic [OPW:0]   acc_o,
    output logic [OPW-1:0] shf_o
);

    logic [OPW:0] sum;
    logic [OPW:0] trial;

    // Compute the next accumulator/shifter pair for the active opcode.
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path can infer a latch.
        acc_o = acc_i;
        shf_o = shf_i;
        sum   = '0;
        trial = '0;
        if (op_i == OP_DIV) begin
            trial = {acc_i[OPW-1:0], shf_i[OPW-1]};
            if (trial >= {1'b0, opd_i}) begin
                acc_o = trial - {1'b0, opd_i};
                shf_o = {shf_i[OPW-2:0], 1'b1};
            end else begin
                acc_o = trial;
                shf_o = {shf_i[OPW-2:0], 1'b0};
            end
        end else begin
            sum            = shf_i[0] ? (acc_i + {1'b0, opd_i}) : acc_i;
            {acc_o, shf_o} = {1'b0, sum, shf_i[OPW-1:1]};
        end
    end

endmodule

// File: rtl/calc_alu_seq.sv
// Sequential calculator: add/sub in one CALC cycle, mul/div iterate OPW
// cycles, then a single DONE cycle presents the new registered result.
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int OPW  = OPW_DEF,
    parameter int RESW = RESW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    calc_alu_seq_if.slave  bus
);

    localparam int CW = $clog2(OPW + 1);

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    op_t             sel_out_q, sel_out_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [OPW:0]    acc_q, acc_d;
    logic [OPW-1:0]  shf_q, shf_d;
    logic [RESW-1:0] res_q, res_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;

    logic [OPW:0]    step_acc;
    logic [OPW-1:0]  step_shf;
    logic [OPW-1:0]  abs_diff;
    op_t             sel_in;

    assign sel_in   = op_t'(bus.Select);
    assign abs_diff = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);

    calc_iter_step #(.OPW(OPW)) u_step (
        .acc_i (acc_q),
        .shf_i (shf_q),
        .opd_i (b_q),
        .op_i  (op_q),
        .acc_o (step_acc),
        .shf_o (step_shf)
    );

    // Next-state, operand capture, iteration and result packing.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sel_out_d = sel_out_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        shf_d     = shf_q;
        res_d     = res_q;
        neg_d     = neg_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d   = bus.A;
                    b_d   = bus.B;
                    op_d  = sel_in;
                    acc_d = '0;
                    shf_d = bus.A;
                    if (sel_in == OP_DIV && bus.B == '0) begin
                        // Divide by zero needs no iterations: report at once.
                        state_d   = S_DONE;
                        res_d     = '0;
                        neg_d     = 1'b0;
                        err_d     = 1'b1;
                        sel_out_d = sel_in;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = (sel_in == OP_MUL || sel_in == OP_DIV) ? CW'(OPW) : CW'(1);
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                acc_d = step_acc;
                shf_d = step_shf;
                if (cnt_q == CW'(1)) begin
                    state_d   = S_DONE;
                    sel_out_d = op_q;
                    neg_d     = 1'b0;
                    err_d     = 1'b0;
                    case (op_q)
                        OP_ADD:  res_d = RESW'(a_q) + RESW'(b_q);
                        OP_SUB: begin
                            res_d = RESW'(abs_diff);
                            neg_d = (a_q < b_q);
                        end
                        OP_MUL:  res_d = RESW'({step_acc, step_shf});
                        OP_DIV:  res_d = (RESW'(step_shf) << (RESW / 2)) | RESW'(step_acc);
                        default: res_d = '0;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath is a handful of flops, not a memory, so all of it is cleared on reset.
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            sel_out_q <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            shf_q     <= '0;
            res_q     <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            op_q      <= op_d;
            sel_out_q <= sel_out_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            shf_q     <= shf_d;
            res_q     <= res_d;
            neg_q     <= neg_d;
            err_q     <= err_d;
        end
    end

    assign bus.res        = res_q;
    assign bus.Select_out = sel_out_q;
    assign bus.neg        = neg_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_calc_alu_seq.sv
// Self-checking bench for calc_alu_seq: directed cases with literal
// expectations plus randomized traffic against a cycle-count/arithmetic model.
module tb_calc_alu_seq;

    localparam int OPW  = 5;
    localparam int RESW = 12;

    logic clk;
    logic rst;
    logic chk_en;
    int   compared;
    int   mismatched;

    calc_alu_seq_if #(.OPW(OPW), .RESW(RESW)) bus ();

    calc_alu_seq #(.OPW(OPW), .RESW(RESW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: busy lasts L cycles after acceptance, done in the last.
    int          m_cnt;
    logic [11:0] m_res, p_res;
    logic [1:0]  m_sel, p_sel;
    logic        m_neg, p_neg, m_err, p_err;

    initial begin
        m_cnt = 0;
        m_res = '0; m_sel = '0; m_neg = 1'b0; m_err = 1'b0;
        p_res = '0; p_sel = '0; p_neg = 1'b0; p_err = 1'b0;
    end

    always @(posedge clk) begin
        int a, b;
        if (rst) begin
            m_cnt = 0;
            m_res = '0; m_sel = '0; m_neg = 1'b0; m_err = 1'b0;
        end else begin
            if (m_cnt == 0) begin
                if (bus.start) begin
                    a = int'(bus.A);
                    b = int'(bus.B);
                    p_sel = bus.Select;
                    p_neg = 1'b0;
                    p_err = 1'b0;
                    case (bus.Select)
                        2'd0: begin p_res = 12'(a + b); m_cnt = 2; end
                        2'd1: begin
                            p_res = 12'((a >= b) ? a - b : b - a);
                            p_neg = (a < b);
                            m_cnt = 2;
                        end
                        2'd2: begin p_res = 12'(a * b); m_cnt = OPW + 1; end
                        default: begin
                            if (b == 0) begin
                                p_res = '0; p_err = 1'b1; m_cnt = 1;
                            end else begin
                                p_res = 12'((a / b) * 64 + (a % b));
                                m_cnt = OPW + 1;
                            end
                        end
                    endcase
                end
            end else begin
                m_cnt--;
            end
            if (m_cnt == 1) begin
                m_res = p_res; m_sel = p_sel; m_neg = p_neg; m_err = p_err;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", 32'(bus.busy), 32'(m_cnt != 0));
            check("cyc done", 32'(bus.done), 32'(m_cnt == 1));
            check("cyc res", 32'(bus.res), 32'(m_res));
            check("cyc sel_out", 32'(bus.Select_out), 32'(m_sel));
            check("cyc neg", 32'(bus.neg), 32'(m_neg));
            check("cyc err", 32'(bus.err), 32'(m_err));
        end
    end

    task automatic wait_idle(input string tag);
        int g = 0;
        while (bus.busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        check({tag, " reach idle"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic scramble();
        bus.A      = 5'($urandom);
        bus.B      = 5'($urandom);
        bus.Select = 2'($urandom);
    endtask

    task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sel,
                          input logic [11:0] exp_res, input logic exp_neg, input logic exp_err,
                          input int exp_lat, input string tag);
        int lat;
        wait_idle(tag);
        bus.start  = 1'b1;
        bus.A      = a;
        bus.B      = b;
        bus.Select = sel;
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            scramble();
            lat++;
        end
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " res"}, 32'(bus.res), 32'(exp_res));
        check({tag, " neg"}, 32'(bus.neg), 32'(exp_neg));
        check({tag, " err"}, 32'(bus.err), 32'(exp_err));
        check({tag, " sel_out"}, 32'(bus.Select_out), 32'(sel));
        @(negedge clk);
        check({tag, " idle after done"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int ndone;
        compared   = 0;
        mismatched = 0;
        chk_en     = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.Select = '0;

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset res", 32'(bus.res), 32'd0);
        check("reset sel_out", 32'(bus.Select_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(5'd13, 5'd9,  2'b00, 12'h016, 1'b0, 1'b0, 2, "add 13+9");
        run_op(5'd7,  5'd12, 2'b01, 12'h005, 1'b1, 1'b0, 2, "sub 7-12");
        run_op(5'd12, 5'd7,  2'b01, 12'h005, 1'b0, 1'b0, 2, "sub 12-7");
        run_op(5'd31, 5'd31, 2'b10, 12'h3C1, 1'b0, 1'b0, 6, "mul 31*31");
        run_op(5'd0,  5'd31, 2'b10, 12'h000, 1'b0, 1'b0, 6, "mul 0*31");
        run_op(5'd29, 5'd4,  2'b11, 12'h1C1, 1'b0, 1'b0, 6, "div 29/4");
        run_op(5'd3,  5'd5,  2'b11, 12'h003, 1'b0, 1'b0, 6, "div 3/5");
        run_op(5'd5,  5'd0,  2'b11, 12'h000, 1'b0, 1'b1, 1, "div 5/0");

        // start held high across a mul: one done, next op only from IDLE.
        wait_idle("held start");
        bus.start  = 1'b1;
        bus.A      = 5'd3;
        bus.B      = 5'd5;
        bus.Select = 2'b10;
        ndone = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            scramble();
        end
        check("held start done count", 32'(ndone), 32'd1);
        check("held start mul res", 32'(bus.res), 32'd15);
        check("held start mul sel_out", 32'(bus.Select_out), 32'd2);
        bus.A      = 5'd1;
        bus.B      = 5'd2;
        bus.Select = 2'b00;
        @(negedge clk);
        check("held start idle gap", 32'(bus.busy), 32'd0);
        check("held start no extra done", 32'(bus.done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("held start 2nd done", 32'(bus.done), 32'd1);
        check("held start 2nd res", 32'(bus.res), 32'd3);
        check("held start 2nd sel_out", 32'(bus.Select_out), 32'd0);

        // Reset in the 3rd CALC cycle of a div, with start asserted on that edge.
        wait_idle("mid reset");
        bus.start  = 1'b1;
        bus.A      = 5'd29;
        bus.B      = 5'd4;
        bus.Select = 2'b11;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("mid reset busy", 32'(bus.busy), 32'd0);
        check("mid reset done", 32'(bus.done), 32'd0);
        check("mid reset res", 32'(bus.res), 32'd0);
        check("mid reset sel_out", 32'(bus.Select_out), 32'd0);
        check("mid reset neg", 32'(bus.neg), 32'd0);
        check("mid reset err", 32'(bus.err), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("mid reset no done", 32'(ndone), 32'd0);
        run_op(5'd29, 5'd4, 2'b11, 12'h1C1, 1'b0, 1'b0, 6, "div after reset");

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 299) == 0);
            bus.start  = ($urandom_range(0, 2) == 0);
            bus.A      = 5'($urandom);
            bus.B      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            bus.Select = 2'($urandom);
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/calc_alu_seq.md
CALC_ALU_SEQ -- requirements
Module: calc_alu_seq

Interface
REQ-001 Parameter OPW, default 5, operand width in bits.
REQ-002 Parameter RESW, default 12, packed result width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 A  input  OPW  first operand, unsigned.
REQ-007 B  input  OPW  second operand, unsigned.
REQ-008 Select  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 res  output  RESW  packed result, registered.
REQ-010 Select_out  output  2  opcode of the operation that produced res.
REQ-011 neg  output  1  sub result negative (A<B).
REQ-012 err  output  1  divide by zero.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse; res, Select_out, neg and err are valid and new.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-016 In IDLE with start=1 at rising edge E0, A, B and Select SHALL be latched and the FSM SHALL go to CALC with the iteration count N loaded (N=1 for add/sub, N=OPW for mul/div).
REQ-017 Div with B=0 at E0 SHALL skip CALC and go directly to DONE with err=1, res=0 and neg=0.
REQ-018 CALC SHALL perform one iteration per cycle and SHALL go to DONE at edge E_N; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-019 done SHALL be 1 only while in DONE, so done is high in the cycle following E_N.
REQ-020 Add SHALL produce res = zero-extended A+B; neg=0; err=0.
REQ-021 Sub SHALL produce res[4:0] = |A-B|, res[11:5] = 0 and neg = (A<B).
REQ-022 Mul SHALL be an iterative shift-add over OPW cycles with res = A*B (max 961, fits 12 bits).
REQ-023 Div SHALL be restoring over OPW cycles with res[11:6] = quotient zero-extended and res[5:0] = remainder zero-extended.
REQ-024 res, Select_out, neg and err SHALL update only on entry to DONE and SHALL hold their values in IDLE and CALC.
REQ-025 start in CALC or DONE SHALL be ignored and not queued; A, B and Select changes after E0 SHALL have no effect.
REQ-026 Back-to-back operation: start may be accepted in the first IDLE cycle after DONE.

Reset
REQ-027 rst=1 at any edge, including mid-CALC, SHALL force IDLE, res=0, Select_out=00, neg=0, err=0, busy=0, done=0 and clear all internal datapath registers.
REQ-028 rst SHALL take priority over start on the same edge.

Structure
REQ-029 Opcode encodings (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the FSM state type and OPW/RESW defaults SHALL live in shared package calc_pkg.
REQ-030 One combinational sub-module, calc_iter_step, SHALL compute one mul/div iteration from {accumulator, shifter, opcode}; the FSM and registers stay in calc_alu_seq.

Verification
REQ-031 A=13, B=9, Select=00, start pulse -> done in 2nd cycle after E0, res=0x016, neg=0, busy high for 2 cycles.
REQ-032 A=7, B=12, Select=01 -> res=0x005, neg=1; then A=12, B=7 -> res=0x005, neg=0.
REQ-033 A=31, B=31, Select=10 -> done in 6th cycle after E0, res=0x3C1; A=0, B=31 -> res=0x000.
REQ-034 A=29, B=4, Select=11 -> res=0x1C1 (q=7, r=1); A=3, B=5 -> res=0x003; A=5, B=0 -> done in 1st cycle after E0, err=1, res=0x000.
REQ-035 start held high throughout a mul -> exactly one done; second op accepted only in IDLE; Select_out tracks the accepted opcode.
REQ-036 rst asserted in 3rd CALC cycle of a div -> next cycle IDLE, all outputs 0, no done pulse; a new op afterwards produces correct results.
